// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX frame buffer.
package eth_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_VERDICT
  } wr_state_e;

  localparam int unsigned FCS_LEN = 4;

endpackage

// File: rtl/eth_rx_frame_buf_if.sv
// Byte-path input, AXI-Stream style output and statistics of the RX frame buffer.
interface eth_rx_frame_buf_if;

  logic        Byte_Rdy;
  logic [7:0]  Byte;
  logic        Crc_En;
  logic        Crc_Valid;
  logic [7:0]  M_Tdata;
  logic        M_Tvalid;
  logic        M_Tlast;
  logic        M_Tready;
  logic [15:0] Frame_Cnt;
  logic [15:0] Drop_Cnt;

  modport slave (
    input  Byte_Rdy, Byte, Crc_En, Crc_Valid, M_Tready,
    output M_Tdata, M_Tvalid, M_Tlast, Frame_Cnt, Drop_Cnt
  );

  modport master (
    output Byte_Rdy, Byte, Crc_En, Crc_Valid, M_Tready,
    input  M_Tdata, M_Tvalid, M_Tlast, Frame_Cnt, Drop_Cnt
  );

endinterface

// File: rtl/eth_rx_len_fifo.sv
// Synchronous FIFO of committed frame lengths; head is visible combinationally.
module eth_rx_len_fifo #(
  parameter int unsigned pDepth = 4,
  parameter int unsigned pWidth = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [pWidth-1:0] i_data,
  input  logic              i_pop,
  output logic [pWidth-1:0] o_head_c,
  output logic              o_full_c,
  output logic              o_empty_c
);

  localparam int unsigned IW = (pDepth > 1) ? $clog2(pDepth) : 1;

  logic [pWidth-1:0] r_mem [pDepth];
  logic [IW:0]       r_wr;
  logic [IW:0]       r_rd;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty_c = (r_wr == r_rd);
  assign o_full_c  = (r_wr[IW] != r_rd[IW]) && (r_wr[IW-1:0] == r_rd[IW-1:0]);
  assign o_head_c  = r_mem[r_rd[IW-1:0]];
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[IW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (IW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (IW+1)'(1);
    end
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// RX frame buffer: stores frames, commits CRC-good ones without FCS, drops the rest,
// and streams committed frames out one frame per Tlast.
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int unsigned pAddr_Width   = 11,
  parameter int unsigned pFrame_Slots  = 4,
  parameter int unsigned pVerdict_Wait = 4
) (
  input logic               Clk,
  input logic               Rst,
  eth_rx_frame_buf_if.slave bus
);

  localparam int unsigned PW    = pAddr_Width + 1;
  localparam int unsigned DEPTH = 1 << pAddr_Width;
  localparam int unsigned VW    = (pVerdict_Wait > 1) ? $clog2(pVerdict_Wait) : 1;

  logic [7:0]    r_mem [DEPTH];
  wr_state_e     r_state;
  logic [PW-1:0] r_wr_ptr, r_wr_commit, r_start_ptr, r_byte_cnt;
  logic [PW-1:0] r_rd_ptr, r_rd_addr, r_iss_cnt;
  logic          r_ovf, r_aged, r_iss_done;
  logic [VW-1:0] r_wait;
  logic [15:0]   r_frame_cnt, r_drop_cnt;
  logic [7:0]    r_tdata;
  logic          r_tvalid, r_tlast;

  logic [PW-1:0] w_used, w_len, w_commit_ptr, w_head_len;
  logic          w_full, w_wr_en, w_ok, w_decide, w_commit, w_drop;
  logic          w_fifo_full, w_fifo_empty, w_rd_en, w_pop, w_iss_last;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == PW'(DEPTH));
  assign w_wr_en      = bus.Byte_Rdy && !w_full && (r_state != S_VERDICT);
  assign w_len        = r_byte_cnt - PW'(FCS_LEN);
  assign w_commit_ptr = r_start_ptr + w_len;
  assign w_ok         = bus.Crc_Valid && !r_ovf && (r_byte_cnt > PW'(FCS_LEN)) && !w_fifo_full;
  assign w_decide     = (r_state == S_VERDICT) &&
                        (bus.Crc_Valid || (r_wait == VW'(pVerdict_Wait - 1)));
  assign w_commit     = w_decide && w_ok;
  assign w_drop       = w_decide && !w_ok;

  eth_rx_len_fifo #(
    .pDepth (pFrame_Slots),
    .pWidth (PW)
  ) u_len_fifo (
    .i_clk     (Clk),
    .i_rst_n   (Rst),
    .i_push    (w_commit),
    .i_data    (w_len),
    .i_pop     (w_pop),
    .o_head_c  (w_head_len),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[pAddr_Width-1:0]] <= bus.Byte;
  end

  // Write side: capture, then commit (FCS rewound) or rewind to last commit point.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_start_ptr <= '0;
      r_byte_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_aged      <= 1'b0;
      r_wait      <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.Byte_Rdy) begin
            r_start_ptr <= r_wr_ptr;
            r_byte_cnt  <= PW'(1);
            r_ovf       <= w_full;
            r_aged      <= 1'b0;
            r_state     <= S_FRAME;
          end
        end
        S_FRAME: begin
          r_aged <= 1'b1;
          if (bus.Byte_Rdy) begin
            r_byte_cnt <= r_byte_cnt + PW'(1);
            if (w_full) r_ovf <= 1'b1;
          end
          if (!bus.Crc_En && r_aged) begin
            r_wait  <= '0;
            r_state <= S_VERDICT;
          end
        end
        S_VERDICT: begin
          r_wait <= r_wait + VW'(1);
          if (w_commit) begin
            r_wr_ptr    <= w_commit_ptr;
            r_wr_commit <= w_commit_ptr;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= S_IDLE;
          end else if (w_drop) begin
            r_wr_ptr   <= r_wr_commit;
            r_drop_cnt <= r_drop_cnt + 16'd1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read side: the next frame is not issued until the head frame's Tlast pops it.
  assign w_rd_en    = !w_fifo_empty && !r_iss_done && (!r_tvalid || bus.M_Tready);
  assign w_pop      = r_tvalid && bus.M_Tready && r_tlast;
  assign w_iss_last = (r_iss_cnt == (w_head_len - PW'(1)));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_rd_ptr   <= '0;
      r_rd_addr  <= '0;
      r_iss_cnt  <= '0;
      r_iss_done <= 1'b0;
      r_tdata    <= 8'h00;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_tdata   <= r_mem[r_rd_addr[pAddr_Width-1:0]];
        r_tvalid  <= 1'b1;
        r_tlast   <= w_iss_last;
        r_rd_addr <= r_rd_addr + PW'(1);
        r_iss_cnt <= w_iss_last ? '0 : r_iss_cnt + PW'(1);
        if (w_iss_last) r_iss_done <= 1'b1;
      end else if (bus.M_Tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_pop) begin
        r_iss_done <= 1'b0;
        r_rd_ptr   <= r_rd_addr;
      end
    end
  end

  assign bus.M_Tdata   = r_tdata;
  assign bus.M_Tvalid  = r_tvalid;
  assign bus.M_Tlast   = r_tlast;
  assign bus.Frame_Cnt = r_frame_cnt;
  assign bus.Drop_Cnt  = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Directed scoreboard bench for eth_rx_frame_buf with a 64-byte RAM and 4 frame slots.
module tb_eth_rx_frame_buf;

  localparam int unsigned AW = 6;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  eth_rx_frame_buf_if bus ();

  eth_rx_frame_buf #(
    .pAddr_Width   (AW),
    .pFrame_Slots  (4),
    .pVerdict_Wait (4)
  ) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  beat_t exp_q[$];
  int    n_vec      = 0;
  int    n_err      = 0;
  int    n_last     = 0;
  int    exp_frames = 0;
  int    exp_drops  = 0;
  int    rdy_mode   = 1;
  int    last_mark  = 0;
  bit    prev_stall = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_frame_cnt"}, 32'(bus.Frame_Cnt), 32'(exp_frames & 16'hFFFF));
    chk({tag, "_drop_cnt"},  32'(bus.Drop_Cnt),  32'(exp_drops & 16'hFFFF));
  endtask

  // Drives one frame; expected payload (all but the FCS) is queued when it will commit.
  task automatic send_frame(input int n, input bit good, input int gap,
                            input bit exp_commit, input bit chk_lat);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      if (exp_commit && (i < n - 4)) exp_q.push_back('{d: d, l: (i == n - 5)});
      bus.Byte_Rdy = 1'b1;
      bus.Byte     = d;
      bus.Crc_En   = (i > 0);
      tick();
      bus.Byte_Rdy = 1'b0;
      bus.Crc_En   = 1'b1;
      if (i < n - 1) repeat (gap - 1) tick();
    end
    bus.Crc_En = 1'b0;
    tick();
    tick();
    bus.Crc_Valid = good;
    tick();
    bus.Crc_Valid = 1'b0;
    if (exp_commit) exp_frames++;
    else            exp_drops++;
    if (chk_lat) begin
      chk("latency_commit_plus1", 32'(bus.M_Tvalid), 32'd0);
      tick();
      chk("latency_commit_plus2", 32'(bus.M_Tvalid), 32'd1);
    end
    repeat (5) tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    bus.M_Tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.M_Tready = 1'b0;
        1:       bus.M_Tready = 1'b1;
        default: bus.M_Tready = ~bus.M_Tready;
      endcase
    end
  end

  // Output monitor: every valid beat must match the scoreboard head, stalled or not.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold_tvalid", 32'(bus.M_Tvalid), 32'd1);
        if (bus.M_Tvalid) begin
          chk("spurious_beat", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            chk("tdata", 32'(bus.M_Tdata), 32'(exp_q[0].d));
            chk("tlast", 32'(bus.M_Tlast), 32'(exp_q[0].l));
            if (bus.M_Tready) begin
              if (exp_q[0].l) n_last++;
              void'(exp_q.pop_front());
            end
          end
        end
        prev_stall = bus.M_Tvalid && !bus.M_Tready;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Byte_Rdy  = 1'b0;
    bus.Byte      = 8'h00;
    bus.Crc_En    = 1'b0;
    bus.Crc_Valid = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 32'(bus.M_Tvalid), 32'd0);
    chk("rst_tlast",  32'(bus.M_Tlast),  32'd0);
    chk("rst_tdata",  32'(bus.M_Tdata),  32'd0);
    chk_cnts("rst");
    rst_n = 1'b1;
    tick();

    // Good 64-byte frame fills the 64-byte RAM exactly; 60 bytes out.
    rdy_mode = 1;
    tick();
    send_frame(64, 1'b1, 4, 1'b1, 1'b1);
    wait_drain("good64", 400);
    chk("good64_tlasts", 32'(n_last), 32'd1);
    chk_cnts("good64");

    // Bad CRC dropped, following good frame reuses the rewound space.
    send_frame(64, 1'b0, 4, 1'b0, 1'b0);
    chk("bad_no_output", 32'(bus.M_Tvalid), 32'd0);
    chk_cnts("badcrc");
    send_frame(30, 1'b1, 2, 1'b1, 1'b1);
    wait_drain("after_bad", 200);
    chk_cnts("after_bad");

    // Runts: 4 bytes is pure FCS and drops, 5 bytes yields a 1-byte frame.
    send_frame(4, 1'b1, 3, 1'b0, 1'b0);
    chk_cnts("runt4");
    send_frame(5, 1'b1, 3, 1'b1, 1'b1);
    wait_drain("runt5", 50);
    chk_cnts("runt5");

    // Backpressure: Tready toggles every cycle across two back-to-back frames.
    last_mark = n_last;
    rdy_mode  = 2;
    send_frame(20, 1'b1, 2, 1'b1, 1'b0);
    send_frame(20, 1'b1, 2, 1'b1, 1'b0);
    wait_drain("bp", 300);
    chk("bp_tlasts", 32'(n_last - last_mark), 32'd2);
    chk_cnts("bp");

    // Overflow: the second 40-byte frame cannot fit beside the first held one.
    rdy_mode = 0;
    repeat (2) tick();
    send_frame(40, 1'b1, 1, 1'b1, 1'b0);
    send_frame(40, 1'b1, 1, 1'b0, 1'b0);
    chk_cnts("ovf");
    rdy_mode = 1;
    wait_drain("ovf", 200);

    // Length FIFO full: fifth committed-looking frame is dropped.
    last_mark = n_last;
    rdy_mode  = 0;
    repeat (2) tick();
    for (int f = 0; f < 5; f++) send_frame(8, 1'b1, 2, (f < 4), 1'b0);
    chk_cnts("slots");
    rdy_mode = 1;
    wait_drain("slots", 200);
    chk("slots_tlasts", 32'(n_last - last_mark), 32'd4);

    // Reset with a committed frame pending and another frame in progress.
    rdy_mode = 0;
    repeat (2) tick();
    send_frame(10, 1'b1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.Byte_Rdy = 1'b1;
      bus.Byte     = 8'($urandom);
      bus.Crc_En   = (i > 0);
      tick();
      bus.Byte_Rdy = 1'b0;
      bus.Crc_En   = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    tick();
    rst_n      = 1'b1;
    bus.Crc_En = 1'b0;
    chk("midrst_tvalid", 32'(bus.M_Tvalid), 32'd0);
    chk_cnts("midrst");
    rdy_mode = 1;
    repeat (3) tick();
    send_frame(12, 1'b1, 2, 1'b1, 1'b1);
    wait_drain("post_rst", 100);
    chk_cnts("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_buf.md
Name: eth_rx_frame_buf

Overview:
- Downstream consumer of the RX byte path and the RX control block.
- Captures every assembled frame byte (DA through FCS) into a byte RAM, then waits for the CRC verdict.
- Good frames are committed with the FCS stripped. Bad, runt or overflowed frames are rewound and dropped.
- Committed frames are presented to the user logic on an AXI-Stream style master port, one frame per Tlast.

Parameters:
- pAddr_Width, 11, byte RAM depth = 2^pAddr_Width (2048 bytes).
- pFrame_Slots, 4, depth of the committed-frame length FIFO (power of 2).
- pVerdict_Wait, 4, cycles after Crc_En falls during which a Crc_Valid pulse is accepted.

Ports:
- Clk  in  1  system clock (50 MHz RMII domain).
- Rst  in  1  synchronous, active-low reset (Rst=0 resets on the Clk edge).
- Byte_Rdy  in  1  one-cycle strobe, Byte valid.
- Byte  in  8  received byte, first-received byte first.
- Crc_En  in  1  high while the frame is in progress; rises the cycle after the first Byte_Rdy.
- Crc_Valid  in  1  one-cycle pulse, FCS matched; absent means bad frame.
- M_Tdata  out  8  frame byte.
- M_Tvalid  out  1  M_Tdata valid.
- M_Tlast  out  1  last byte of frame (last payload byte; FCS excluded).
- M_Tready  in  1  consumer accepts.
- Frame_Cnt  out  16  committed frames, wraps.
- Drop_Cnt  out  16  dropped frames, wraps.

Behaviour:
Reset (Rst=0):
- All pointers, the length FIFO, counters, M_Tvalid and M_Tlast go to 0; FSM goes to S_IDLE. M_Tdata resets to 0x00.
- A reset mid-frame or mid-read discards everything, including committed frames.

Write FSM:
- S_IDLE: on Byte_Rdy, write Byte at wr_ptr, set start_ptr=wr_ptr, byte_cnt=1, ovf=0, go to S_FRAME.
- S_FRAME: each Byte_Rdy writes at wr_ptr+1 and increments byte_cnt. If the RAM is full (used == 2^pAddr_Width), the byte is not written and ovf=1.
- Exit S_FRAME to S_VERDICT in the first cycle with Crc_En==0, provided at least one cycle has elapsed in S_FRAME. A Byte_Rdy in that same cycle is still written.
- S_VERDICT: a wait counter counts 0..pVerdict_Wait-1.
  - Commit if Crc_Valid is seen, ovf==0, byte_cnt>4 and the length FIFO is not full. Commit means: push len=byte_cnt-4; wr_commit = start_ptr+len (modulo 2^pAddr_Width); Frame_Cnt+1.
  - Otherwise drop: wr_ptr rewinds to wr_commit; Drop_Cnt+1.
  - Either way the decision is taken in the cycle Crc_Valid is seen, or at timeout. Then go to S_IDLE.
  - Byte_Rdy is ignored in S_VERDICT.

Pointers and space:
- All pointers are pAddr_Width+1 bits; the MSB distinguishes full from empty.
- used = wr_ptr - rd_ptr.
- The FCS bytes occupy RAM only until commit or drop.

Read side:
- The RAM has a synchronous read port. A prefetch register feeds M_Tdata.
- M_Tvalid first rises 2 cycles after the commit cycle when the buffer was previously empty.
- When M_Tvalid=1 and M_Tready=0, M_Tdata and M_Tlast hold stable.
- With M_Tready held at 1, one byte transfers per cycle with no bubbles within a frame. A bubble of at most 1 cycle is allowed between frames.
- M_Tlast asserts with byte len-1 of the head frame. On that handshake the length FIFO pops and rd_ptr advances.

Simultaneous events:
- A commit and a pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- A read never crosses wr_commit.

Decomposition:
- eth_pkg: write FSM state enum (S_IDLE, S_FRAME, S_VERDICT) and the FCS length constant 4.
- Sub-module eth_rx_len_fifo: synchronous FIFO, pFrame_Slots x (pAddr_Width+1) bits, with push/pop/full/empty. Instantiated once.
- The byte RAM is inferred inline.

Test Plan:
- Good frame: 64 Byte_Rdy strobes 4 cycles apart, Crc_En falls, Crc_Valid 2 cycles later, M_Tready=1 -> 60 bytes out matching input[0..59], Tlast on byte 60, Frame_Cnt=1, Drop_Cnt=0.
- Bad CRC: same frame, no Crc_Valid -> no M_Tvalid, Drop_Cnt=1. A following good frame is output starting at the same RAM address.
- Runt: 4 bytes then Crc_Valid -> dropped, Drop_Cnt=1. Also: 5 bytes with Crc_Valid -> 1-byte frame with Tlast on its only byte.
- Backpressure: 2 good 20-byte frames, M_Tready toggling 1/0 every cycle -> 16+16 bytes in order, Tdata stable while stalled, exactly 2 Tlast.
- Overflow: pAddr_Width=6, M_Tready=0, one 40-byte good frame, then a 40-byte frame -> second frame dropped (ovf). After M_Tready=1, only the first 36 bytes appear; Drop_Cnt=1.
- Slot full and reset: pFrame_Slots=4, M_Tready=0, 5 good frames -> 5th dropped. Rst=0 mid-frame for 1 cycle -> M_Tvalid=0, counters=0, next frame captured normally.
